// File: rtl/enigma_pkg.sv
// enigma_pkg: character/bus types, FSM states, rotor and reflector wirings, mod-26 helpers.
// Latency: none; it holds declarations only.
// Backpressure: none.
package enigma_pkg;

  localparam int CHAR_W  = 5;
  localparam int ALPHA   = 26;
  localparam int N_PAIRS = 5;

  typedef logic [CHAR_W-1:0]             char_t;
  typedef logic [2*N_PAIRS-1:0][CHAR_W-1:0] pb_t;   // plugboard entries 0..9
  typedef logic [2:0][CHAR_W-1:0]        pos_t;     // {p3,p2,p1}

  localparam char_t ALPHA_C = char_t'(ALPHA);
  localparam char_t LAST_C  = char_t'(ALPHA - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_PB_IN, S_FWD, S_REFL, S_BWD, S_PB_OUT, S_DONE
  } state_t;

  // Wirings I, II, III as letter indices (A=0); sel 3 is handled as identity.
  localparam char_t ROT_FWD [3][26] = '{
    '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9},
    '{0,9,3,10,18,8,17,20,23,1,11,7,22,19,12,2,16,6,25,13,15,24,5,21,14,4},
    '{1,3,5,7,9,11,2,15,17,19,23,21,25,13,24,4,8,22,6,0,10,12,20,18,16,14}
  };

  localparam char_t ROT_INV [3][26] = '{
    '{20,22,24,6,0,3,5,15,21,25,1,4,2,10,12,19,7,23,18,11,17,8,13,16,14,9},
    '{0,9,15,2,25,22,17,11,5,1,3,10,14,19,24,20,16,6,4,13,7,23,12,8,21,18},
    '{19,0,6,1,15,2,18,3,16,4,20,5,21,13,25,7,24,8,23,9,22,11,17,10,14,12}
  };

  localparam char_t UKW_B [26] =
    '{24,17,20,7,16,18,11,3,15,23,13,6,14,10,12,8,4,1,5,25,2,22,21,9,0,19};

  // Operands are always < 26, so one conditional correction suffices.
  function automatic char_t add26(input char_t a, input char_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(ALPHA)) s = s - 6'(ALPHA);
    return s[CHAR_W-1:0];
  endfunction

  function automatic char_t sub26(input char_t a, input char_t b);
    logic [5:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + 6'(ALPHA);
    return d[CHAR_W-1:0];
  endfunction

endpackage

// File: rtl/enigma_if.sv
// enigma_if: request/config inputs and result/status outputs of the cipher core.
// Latency: none; wires only.
// Backpressure: none; busy tells the master that starts are being dropped.
interface enigma_if;
  import enigma_pkg::*;

  logic       start;
  char_t      char_in;
  pb_t        pb_lut;
  logic [1:0] r1_cfg;
  logic [1:0] r2_cfg;
  logic [1:0] r3_cfg;
  logic       pos_clr;
  char_t      char_out;
  logic       done;
  logic       busy;
  logic       err;
  pos_t       pos;

  modport master (
    output start, char_in, pb_lut, r1_cfg, r2_cfg, r3_cfg, pos_clr,
    input  char_out, done, busy, err, pos
  );

  modport slave (
    input  start, char_in, pb_lut, r1_cfg, r2_cfg, r3_cfg, pos_clr,
    output char_out, done, busy, err, pos
  );

endinterface

// File: rtl/enigma_rotor_map.sv
// enigma_rotor_map: one rotor pass, y = W[(x+pos)%26] - pos (mod 26), W or its inverse.
// Latency: combinational.
// Backpressure: none.
// Ports: x/pos in (char), sel in (0:I 1:II 2:III 3:identity), dir in (1 = inverse), y out.
module enigma_rotor_map
  import enigma_pkg::*;
(
  input  char_t      x,
  input  char_t      pos,
  input  logic [1:0] sel,
  input  logic       dir,
  output char_t      y
);

  char_t idx;
  char_t w;

  always_comb begin
    idx = add26(x, pos);
    w   = idx;
    if (sel != 2'd3) begin
      w = dir ? ROT_INV[sel][idx] : ROT_FWD[sel][idx];
    end
    y = sub26(w, pos);
  end

endmodule

// File: rtl/enigma_core.sv
// enigma_core: enciphers one character per start (step, plugboard, 3 rotors, reflector, back).
// Latency: start sampled at edge k -> done pulse and new char_out in cycle k+11; busy k+1..k+11.
// Backpressure: none; a start while busy is dropped, pos_clr is ignored while busy.
// Ports: clk, reset (sync, active-high); bus (enigma_if.slave) carries start/char_in/pb_lut/
//        r*_cfg/pos_clr in and char_out/done/busy/err/pos out.
module enigma_core
  import enigma_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  enigma_if.slave bus
);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      stage;
  pos_t            p;
  char_t           cur;
  char_t           char_cap;
  char_t           out_q;
  pb_t             pb_cap;
  logic [2:0][1:0] cfg_cap;
  logic            bad;
  logic [1:0]      ridx;
  logic            rot_dir;
  char_t           rot_y;
  logic            busy;
  logic            done;

  // Lowest-index valid pair containing x decides; a==b or out-of-alphabet pairs never match.
  function automatic char_t plug(input char_t x, input pb_t lut);
    char_t r;
    char_t a;
    char_t b;
    logic  hit;
    r   = x;
    hit = 1'b0;
    for (int k = 0; k < N_PAIRS; k++) begin
      a = lut[2*k];
      b = lut[2*k+1];
      if (!hit && (a != b) && (a < ALPHA_C) && (b < ALPHA_C) && (x == a || x == b)) begin
        r   = (x == a) ? b : a;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rot_dir   = 1'b0;
    ridx      = stage;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) state_nxt = S_STEP;
      end
      S_STEP:  state_nxt = S_PB_IN;
      S_PB_IN: state_nxt = S_FWD;
      S_FWD:   if (stage == 2'd2) state_nxt = S_REFL;
      S_REFL:  state_nxt = S_BWD;
      S_BWD: begin
        // Return path walks R3, R2, R1.
        rot_dir = 1'b1;
        ridx    = 2'd2 - stage;
        if (stage == 2'd2) state_nxt = S_PB_OUT;
      end
      S_PB_OUT: state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  enigma_rotor_map u_rotor (
    .x   (cur),
    .pos (p[ridx]),
    .sel (cfg_cap[ridx]),
    .dir (rot_dir),
    .y   (rot_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stage    <= 2'd0;
      p        <= '0;
      cur      <= '0;
      char_cap <= '0;
      out_q    <= '0;
      pb_cap   <= '0;
      cfg_cap  <= '0;
      bad      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          stage <= 2'd0;
          // Clear lands here; a same-cycle start then steps from zero in S_STEP.
          if (bus.pos_clr) p <= '0;
          if (bus.start) begin
            char_cap <= bus.char_in;
            pb_cap   <= bus.pb_lut;
            cfg_cap  <= {bus.r3_cfg, bus.r2_cfg, bus.r1_cfg};
            bad      <= (bus.char_in >= ALPHA_C);
          end
        end
        S_STEP: begin
          // Plain odometer: each rotor carries only when the one below wraps.
          if (!bad) begin
            p[0] <= add26(p[0], 5'd1);
            if (p[0] == LAST_C) begin
              p[1] <= add26(p[1], 5'd1);
              if (p[1] == LAST_C) p[2] <= add26(p[2], 5'd1);
            end
          end
          // Keep table indices in range when the character is invalid.
          cur <= bad ? '0 : char_cap;
        end
        S_PB_IN: cur <= plug(cur, pb_cap);
        S_FWD, S_BWD: begin
          cur   <= rot_y;
          stage <= (stage == 2'd2) ? 2'd0 : stage + 2'd1;
        end
        S_REFL:   cur <= UKW_B[cur];
        S_PB_OUT: out_q <= bad ? char_cap : plug(cur, pb_cap);
        default: ;
      endcase
    end
  end

  assign bus.char_out = out_q;
  assign bus.done     = done;
  assign bus.busy     = busy;
  assign bus.err      = done & bad;
  assign bus.pos      = p;

endmodule

// File: tb/tb_enigma_core.sv
module tb_enigma_core;
  import enigma_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  enigma_if bus ();

  enigma_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  string WIRE [3] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ",
                      "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                      "BDFHJLCPRTXVZNYEIWGAKMUSQO"};
  string UKW = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  pb_t pb_none;
  pb_t pb_mix;
  int  bdzgo [5] = '{1, 3, 25, 6, 14};
  int  ctext [5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: letters, strings and an odometer count ----------------
  function automatic int wire_at(input int sel, input int i);
    if (sel == 3) return i;
    return int'(WIRE[sel].getc(i)) - 65;
  endfunction

  function automatic int wire_inv(input int sel, input int o);
    for (int i = 0; i < 26; i++) if (wire_at(sel, i) == o) return i;
    return 0;
  endfunction

  function automatic int rotor(input int x, input int sel, input int p, input bit inv);
    int i;
    int w;
    i = (x + p) % 26;
    w = inv ? wire_inv(sel, i) : wire_at(sel, i);
    return (w - p + 26) % 26;
  endfunction

  function automatic int plug_m(input int x, input pb_t pb);
    int a;
    int b;
    for (int k = 0; k < 5; k++) begin
      a = int'(pb[2*k]);
      b = int'(pb[2*k+1]);
      if (a == b || a >= 26 || b >= 26) continue;
      if (x == a) return b;
      if (x == b) return a;
    end
    return x;
  endfunction

  // n counts characters since the last clear; positions are its base-26 digits.
  function automatic int model_enc(input int c, input int n, input int s1, input int s2,
                                   input int s3, input pb_t pb);
    int p [3];
    int s [3];
    int x;
    p[0] = n % 26;  p[1] = (n / 26) % 26;  p[2] = (n / 676) % 26;
    s[0] = s1;      s[1] = s2;             s[2] = s3;
    x = plug_m(c, pb);
    for (int r = 0; r < 3; r++) x = rotor(x, s[r], p[r], 1'b0);
    x = int'(UKW.getc(x)) - 65;
    for (int r = 2; r >= 0; r--) x = rotor(x, s[r], p[r], 1'b1);
    return plug_m(x, pb);
  endfunction

  function automatic int next_n(input int n, input bit clr, input bit st, input int c);
    int b;
    b = clr ? 0 : n;
    if (st && c < 26) b = (b + 1) % 17576;
    return b;
  endfunction

  int m_cnt = 0;   // 0 idle, else cycles since the accepted start
  int m_n   = 0;
  int m_res = 0;
  int m_out = 0;
  bit m_err = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0;
      m_n   <= 0;
      m_out <= 0;
      m_err <= 1'b0;
    end else if (m_cnt == 0) begin
      m_n <= next_n(m_n, bus.pos_clr, bus.start, int'(bus.char_in));
      if (bus.start) begin
        m_cnt <= 1;
        m_err <= (int'(bus.char_in) >= 26);
        m_res <= (int'(bus.char_in) >= 26) ? int'(bus.char_in) :
                 model_enc(int'(bus.char_in),
                           next_n(m_n, bus.pos_clr, bus.start, int'(bus.char_in)),
                           int'(bus.r1_cfg), int'(bus.r2_cfg), int'(bus.r3_cfg), bus.pb_lut);
      end
    end else begin
      m_cnt <= (m_cnt == 11) ? 0 : m_cnt + 1;
      if (m_cnt == 10) m_out <= m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(bus.busy), int'(m_cnt != 0));
      check("done", int'(bus.done), int'(m_cnt == 11));
      check("err", int'(bus.err), int'(m_cnt == 11 && m_err));
      check("char_out", int'(bus.char_out), m_out);
      if (m_cnt == 0 || m_cnt == 11) begin
        check("pos_p1", int'(bus.pos[0]), m_n % 26);
        check("pos_p2", int'(bus.pos[1]), (m_n / 26) % 26);
        check("pos_p3", int'(bus.pos[2]), (m_n / 676) % 26);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after done.
  task automatic run_char(input int c, input bit clr, output int out, output int e);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("idle_wait", int'(bus.busy), 0);
    bus.char_in = 5'(c);
    bus.pos_clr = clr;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.pos_clr = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(bus.done), 1);
    out = int'(bus.char_out);
    e   = int'(bus.err);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int o, e, y, prev, done_at, busy_n, dn;
    int xs [3];
    xs = '{7, 12, 25};
    pb_none = {10{5'd31}};
    // pairs: (1,2) (1,5: shadowed) (3,3: no-op) (30,1: no-op) (31,31: no-op)
    pb_mix  = {5'd31, 5'd31, 5'd1, 5'd30, 5'd3, 5'd3, 5'd5, 5'd1, 5'd2, 5'd1};
    bus.start   = 1'b0;
    bus.char_in = '0;
    bus.pos_clr = 1'b0;
    bus.pb_lut  = pb_none;
    bus.r1_cfg  = 2'd2;
    bus.r2_cfg  = 2'd1;
    bus.r3_cfg  = 2'd0;

    do_reset();
    chk_en = 1'b1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_char_out", int'(bus.char_out), 0);
    check("rst_pos", int'(bus.pos), 0);

    // model pinned to known ciphertext: A at position 1 -> B, at position 5 -> O
    check("model_pin_B", model_enc(0, 1, 2, 1, 0, pb_none), 1);
    check("model_pin_O", model_enc(0, 5, 2, 1, 0, pb_none), 14);

    // AAAAA -> BDZGO
    for (int i = 0; i < 5; i++) begin
      run_char(0, 1'b0, o, e);
      ctext[i] = o;
      check("bdzgo", o, bdzgo[i]);
    end
    check("bdzgo_p1", int'(bus.pos[0]), 5);

    // decrypt after reset
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_char(ctext[i], 1'b0, o, e);
      check("decrypt", o, 0);
    end

    // timing, dropped start at k+5, dropped pos_clr at k+3
    prev = int'(bus.pos[0]);
    bus.char_in = 5'd3;
    bus.start   = 1'b1;
    done_at = -1;
    busy_n  = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      bus.start   = (i == 5);
      bus.pos_clr = (i == 3);
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1 && done_at < 0) done_at = i;
    end
    bus.start   = 1'b0;
    bus.pos_clr = 1'b0;
    check("done_latency", done_at, 11);
    check("busy_cycles", busy_n, 11);
    check("ignored_start_p1", int'(bus.pos[0]), (prev + 1) % 26);

    // plugboard priority / no-op pairs; pos_clr with start steps from zero
    bus.pb_lut = pb_mix;
    run_char(0, 1'b1, o, e);
    check("pb_swap_0", o, 2);
    check("clr_start_p1", int'(bus.pos[0]), 1);
    run_char(2, 1'b1, o, e);
    check("pb_swap_2", o, 0);
    for (int i = 0; i < 3; i++) begin
      run_char(xs[i], 1'b1, y, e);
      check("no_fixed_point", int'(y != xs[i]), 1);
      run_char(y, 1'b1, o, e);
      check("involution", o, xs[i]);
    end

    // invalid character
    prev = int'(bus.pos);
    run_char(26, 1'b0, o, e);
    check("inv_char_out", o, 26);
    check("inv_err", e, 1);
    check("inv_pos", int'(bus.pos), prev);
    run_char(0, 1'b0, o, e);
    check("valid_err", e, 0);

    // reset in the middle of a character
    bus.pb_lut  = pb_none;
    bus.char_in = 5'd0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (14) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_char_out", int'(bus.char_out), 0);
    check("abort_pos", int'(bus.pos), 0);
    run_char(0, 1'b0, o, e);
    check("after_abort", o, 1);

    // odometer carry into p3
    do_reset();
    for (int i = 0; i < 675; i++) run_char(0, 1'b0, o, e);
    check("odo_p1", int'(bus.pos[0]), 25);
    check("odo_p2", int'(bus.pos[1]), 25);
    check("odo_p3", int'(bus.pos[2]), 0);
    run_char(0, 1'b0, o, e);
    check("carry_p1", int'(bus.pos[0]), 0);
    check("carry_p2", int'(bus.pos[1]), 0);
    check("carry_p3", int'(bus.pos[2]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
